// File: rtl/ibex_multdiv_issue_pkg.sv
// Shared types for the slow mult/div issue stage: engine op encoding and issue FSM states.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'b00,
        MD_OP_MULH = 2'b01,
        MD_OP_DIV  = 2'b10,
        MD_OP_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MDQ_IDLE = 2'b00,
        MDQ_BUSY = 2'b01,
        MDQ_RESP = 2'b10
    } mdq_state_e;

    function automatic logic md_is_mult(md_op_e op);
        return (op == MD_OP_MULL) || (op == MD_OP_MULH);
    endfunction

endpackage

// File: rtl/ibex_multdiv_issue.sv
// Request/response front end and shared resources (adder, imd regs) for ibex_multdiv_slow.
// Optional MULTDIV_DIT_EN: latch cfg_dit_i at accept and drive data_ind_timing_o from it.
module ibex_multdiv_issue
    import ibex_pkg::*;
#(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  md_op_e           req_op_i,
    input  logic [1:0]       req_signed_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_data_o,
    output logic [CNT_W-1:0] rsp_cycles_o,
    input  logic             cfg_dit_i,
    output logic             mult_en_o,
    output logic             div_en_o,
    output logic             mult_sel_o,
    output logic             div_sel_o,
    output md_op_e           operator_o,
    output logic [1:0]       signed_mode_o,
    output logic [31:0]      op_a_o,
    output logic [31:0]      op_b_o,
    input  logic [32:0]      alu_operand_a_i,
    input  logic [32:0]      alu_operand_b_i,
    output logic [33:0]      alu_adder_ext_o,
    output logic [31:0]      alu_adder_o,
    output logic             equal_to_zero_o,
    output logic             data_ind_timing_o,
    input  logic [33:0]      imd_val_d_i [2],
    input  logic [1:0]       imd_val_we_i,
    output logic [33:0]      imd_val_q_o [2],
    input  logic [31:0]      multdiv_result_i,
    input  logic             valid_i,
    output logic             multdiv_ready_id_o
);

    mdq_state_e       state_q, state_d;
    md_op_e           op_q;
    logic [1:0]       signed_q;
    logic [31:0]      a_q, b_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic [31:0]      data_q;
    logic [CNT_W-1:0] cycles_q;
    logic [33:0]      imd_q [2];
    logic             accept;
    logic             busy;

    assign alu_adder_ext_o = {1'b0, alu_operand_a_i} + {1'b0, alu_operand_b_i};
    assign alu_adder_o     = alu_adder_ext_o[32:1];
    assign equal_to_zero_o = (alu_adder_o == '0);

    assign busy    = (state_q == MDQ_BUSY);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign accept  = req_valid_i && req_ready_o;

    always_comb begin
        state_d            = state_q;
        req_ready_o        = 1'b0;
        rsp_valid_o        = 1'b0;
        mult_en_o          = 1'b0;
        mult_sel_o         = 1'b0;
        div_en_o           = 1'b0;
        div_sel_o          = 1'b0;
        multdiv_ready_id_o = 1'b0;
        case (state_q)
            MDQ_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = MDQ_BUSY;
            end
            MDQ_BUSY: begin
                mult_en_o          = md_is_mult(op_q);
                mult_sel_o         = md_is_mult(op_q);
                div_en_o           = !md_is_mult(op_q);
                div_sel_o          = !md_is_mult(op_q);
                multdiv_ready_id_o = 1'b1;
                if (valid_i) state_d = MDQ_RESP;
            end
            MDQ_RESP: begin
                rsp_valid_o = 1'b1;
                // Consuming the response frees the slot in the same cycle: no bubble between ops.
                if (rsp_ready_i) begin
                    req_ready_o = 1'b1;
                    state_d     = req_valid_i ? MDQ_BUSY : MDQ_IDLE;
                end
            end
            default: state_d = MDQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MDQ_IDLE;
            op_q     <= MD_OP_MULL;
            signed_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            cycles_q <= '0;
            for (int unsigned k = 0; k < 2; k++) imd_q[k] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= req_op_i;
                signed_q <= req_signed_i;
                a_q      <= req_a_i;
                b_q      <= req_b_i;
                cnt_q    <= '0;
            end else if (busy) begin
                cnt_q <= cnt_inc;
            end
            if (busy && valid_i) begin
                data_q   <= multdiv_result_i;
                cycles_q <= cnt_inc;
            end
            for (int unsigned k = 0; k < 2; k++) begin
                if (imd_val_we_i[k] && busy) imd_q[k] <= imd_val_d_i[k];
            end
        end
    end

`ifdef MULTDIV_DIT_EN
    logic dit_q;
    always_ff @(posedge clk) begin
        if (rst)         dit_q <= 1'b0;
        else if (accept) dit_q <= cfg_dit_i;
    end
    assign data_ind_timing_o = dit_q;
`else
    logic unused_cfg_dit;
    assign unused_cfg_dit    = cfg_dit_i;
    assign data_ind_timing_o = 1'b0;
`endif

    assign operator_o    = op_q;
    assign signed_mode_o = signed_q;
    assign op_a_o        = a_q;
    assign op_b_o        = b_q;
    assign rsp_data_o    = data_q;
    assign rsp_cycles_o  = cycles_q;
    assign imd_val_q_o   = imd_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Directed bench for ibex_multdiv_issue with a behavioural stand-in for ibex_multdiv_slow.
module tb_ibex_multdiv_issue;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    md_op_e      req_op;
    logic [1:0]  req_signed;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [5:0]  rsp_cycles;
    logic        cfg_dit;
    logic        mult_en, div_en, mult_sel, div_sel;
    md_op_e      operator;
    logic [1:0]  signed_mode;
    logic [31:0] op_a, op_b;
    logic [32:0] alu_a, alu_b;
    logic [33:0] adder_ext;
    logic [31:0] adder;
    logic        eq_zero, dit_o;
    logic [33:0] imd_d [2];
    logic [33:0] imd_q [2];
    logic [1:0]  imd_we;
    logic [31:0] md_result;
    logic        md_valid, ready_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ibex_multdiv_issue #(.CNT_W(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_signed_i(req_signed), .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_cycles_o(rsp_cycles), .cfg_dit_i(cfg_dit),
        .mult_en_o(mult_en), .div_en_o(div_en), .mult_sel_o(mult_sel), .div_sel_o(div_sel),
        .operator_o(operator), .signed_mode_o(signed_mode), .op_a_o(op_a), .op_b_o(op_b),
        .alu_operand_a_i(alu_a), .alu_operand_b_i(alu_b), .alu_adder_ext_o(adder_ext),
        .alu_adder_o(adder), .equal_to_zero_o(eq_zero), .data_ind_timing_o(dit_o),
        .imd_val_d_i(imd_d), .imd_val_we_i(imd_we), .imd_val_q_o(imd_q),
        .multdiv_result_i(md_result), .valid_i(md_valid), .multdiv_ready_id_o(ready_id)
    );

    // Engine stand-in: MULL exits after (significant bits of b)+1 cycles, MULH takes 33,
    // div/rem take 37 or 2 on divide-by-zero; DIT forces the full length.
    logic [5:0]  eng_cnt;
    logic        eng_en, eng_valid, stray_valid;
    int          eng_lat;
    logic [31:0] eng_res;

    assign eng_en = mult_en | div_en;
    always @(posedge clk) begin
        if (rst || !eng_en) eng_cnt <= '0;
        else                eng_cnt <= eng_cnt + 6'd1;
    end

    always_comb begin
        logic signed [32:0] sa, sb;
        logic signed [65:0] prod;
        logic signed [31:0] qa, qb;
        int nb;
        nb = 0;
        for (int i = 0; i < 32; i++) if (op_b[i]) nb = i + 1;
        sa = {signed_mode[0] & op_a[31], op_a};
        sb = {signed_mode[1] & op_b[31], op_b};
        prod = sa * sb;
        qa = op_a;
        qb = op_b;
        eng_lat = 1;
        eng_res = '0;
        case (operator)
            MD_OP_MULL: begin eng_lat = dit_o ? 33 : nb + 1; eng_res = op_a * op_b; end
            MD_OP_MULH: begin eng_lat = 33; eng_res = prod[63:32]; end
            MD_OP_DIV: begin
                eng_lat = (op_b == 0 && !dit_o) ? 2 : 37;
                if (op_b == 0)               eng_res = '1;
                else if (signed_mode == 2'b11) eng_res = qa / qb;
                else                         eng_res = op_a / op_b;
            end
            default: begin
                eng_lat = (op_b == 0 && !dit_o) ? 2 : 37;
                if (op_b == 0)               eng_res = op_a;
                else if (signed_mode == 2'b11) eng_res = qa % qb;
                else                         eng_res = op_a % op_b;
            end
        endcase
    end

    assign eng_valid = eng_en && (int'(eng_cnt) == eng_lat - 1);
    assign md_valid  = eng_valid | stray_valid;
    assign md_result = eng_valid ? eng_res : 32'h1234_5678;
    assign imd_we    = 2'b11;
    assign imd_d[0]  = {2'b01, 26'b0, eng_cnt};
    assign imd_d[1]  = {2'b11, op_a ^ {26'b0, eng_cnt}};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input md_op_e op, input logic [1:0] sg, input logic [31:0] a, input logic [31:0] b);
        req_op = op; req_signed = sg; req_a = a; req_b = b; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            step();
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({mult_en, div_en, mult_sel, div_sel, ready_id} !== 5'b0) begin bad++; $display("FAIL reset_en got=%b exp=00000", {mult_en, div_en, mult_sel, div_sel, ready_id}); end
        total++; if (imd_q[0] !== 34'h0 || imd_q[1] !== 34'h0) begin bad++; $display("FAIL reset_imd got=%h/%h exp=0/0", imd_q[0], imd_q[1]); end
        total++; if (rsp_data !== 32'h0 || rsp_cycles !== 6'd0) begin bad++; $display("FAIL reset_rsp got=%h/%0d exp=0/0", rsp_data, rsp_cycles); end
        rst = 1'b0;
    endtask

    task automatic test_adder();
        alu_a = 33'h1_FFFF_FFFF; alu_b = 33'h1_FFFF_FFFF; #1;
        total++; if (adder_ext !== 34'h3_FFFF_FFFE || adder !== 32'hFFFF_FFFF || eq_zero !== 1'b0) begin bad++; $display("FAIL adder_max got=%h %h %b exp=3fffffffe ffffffff 0", adder_ext, adder, eq_zero); end
        alu_a = 33'h1_0000_0000; alu_b = 33'h1_0000_0000; #1;
        total++; if (adder_ext !== 34'h2_0000_0000 || adder !== 32'h0 || eq_zero !== 1'b1) begin bad++; $display("FAIL adder_carry got=%h %h %b exp=200000000 0 1", adder_ext, adder, eq_zero); end
        alu_a = 33'd1; alu_b = 33'd1; #1;
        total++; if (adder !== 32'd1 || eq_zero !== 1'b0) begin bad++; $display("FAIL adder_small got=%h %b exp=1 0", adder, eq_zero); end
        alu_a = 33'd1; alu_b = 33'd0; #1;
        total++; if (adder !== 32'd0 || eq_zero !== 1'b1) begin bad++; $display("FAIL adder_lsb got=%h %b exp=0 1", adder, eq_zero); end
    endtask

    task automatic test_mull();
        bit ok;
        issue(MD_OP_MULL, 2'b00, 32'd3, 32'd4);
        total++; if ({mult_en, mult_sel, div_en, div_sel, ready_id, req_ready} !== 6'b110010) begin bad++; $display("FAIL mull_busy_ctl got=%b exp=110010", {mult_en, mult_sel, div_en, div_sel, ready_id, req_ready}); end
        total++; if (operator !== MD_OP_MULL || op_a !== 32'd3 || op_b !== 32'd4) begin bad++; $display("FAIL mull_latched got=%0d %h %h exp=0 3 4", operator, op_a, op_b); end
        wait_rsp(ok);
        total++; if (!ok) begin bad++; $display("FAIL mull_timeout got=no_rsp exp=rsp"); end
        total++; if (rsp_data !== 32'd12 || rsp_cycles !== 6'd4) begin bad++; $display("FAIL mull_rsp got=%0d/%0d exp=12/4", rsp_data, rsp_cycles); end
        total++; if (imd_q[0] !== 34'h1_0000_0003 || imd_q[1] !== 34'h3_0000_0000) begin bad++; $display("FAIL mull_imd got=%h/%h exp=100000003/300000000", imd_q[0], imd_q[1]); end
        total++; if ({mult_en, div_en, ready_id} !== 3'b000) begin bad++; $display("FAIL mull_resp_en got=%b exp=000", {mult_en, div_en, ready_id}); end
        consume();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mull_idle got=%b%b exp=01", rsp_valid, req_ready); end
        stray_valid = 1'b1;
        step();
        stray_valid = 1'b0;
        step();
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 32'd12 || req_ready !== 1'b1) begin bad++; $display("FAIL stray_valid got=%b %h %b exp=0 0000000c 1", rsp_valid, rsp_data, req_ready); end
    endtask

    task automatic test_div_zero();
        bit ok;
        issue(MD_OP_DIV, 2'b00, 32'd100, 32'd0);
        total++; if ({mult_en, div_en, div_sel} !== 3'b011) begin bad++; $display("FAIL div0_busy_ctl got=%b exp=011", {mult_en, div_en, div_sel}); end
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'hFFFF_FFFF || rsp_cycles !== 6'd2) begin bad++; $display("FAIL div0_rsp got=%h/%0d exp=ffffffff/2", rsp_data, rsp_cycles); end
        consume();
        issue(MD_OP_REM, 2'b00, 32'd100, 32'd0);
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'd100 || rsp_cycles !== 6'd2) begin bad++; $display("FAIL rem0_rsp got=%0d/%0d exp=100/2", rsp_data, rsp_cycles); end
        consume();
    endtask

    task automatic test_div_signed();
        bit ok;
        issue(MD_OP_DIV, 2'b11, 32'hFFFF_FFF9, 32'd2);
        total++; if (signed_mode !== 2'b11) begin bad++; $display("FAIL sdiv_mode got=%b exp=11", signed_mode); end
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'hFFFF_FFFD || rsp_cycles !== 6'd37) begin bad++; $display("FAIL sdiv_rsp got=%h/%0d exp=fffffffd/37", rsp_data, rsp_cycles); end
        consume();
        issue(MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'hFFFF_FFFF || rsp_cycles !== 6'd37) begin bad++; $display("FAIL srem_rsp got=%h/%0d exp=ffffffff/37", rsp_data, rsp_cycles); end
        consume();
    endtask

    task automatic test_stall();
        bit ok;
        issue(MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2);
        wait_rsp(ok);
        total++; if (!ok) begin bad++; $display("FAIL mulh_timeout got=no_rsp exp=rsp"); end
        req_op = MD_OP_DIV; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_cycles !== 6'd33 || req_ready !== 1'b0 ||
                operator !== MD_OP_MULH || imd_q[0] !== 34'h1_0000_0020 || imd_q[1] !== 34'h3_8000_0020) begin
                bad++;
                $display("FAIL stall_hold[%0d] got=%b %h %0d %b %0d %h %h exp=1 ffffffff 33 0 1 100000020 380000020",
                         i, rsp_valid, rsp_data, rsp_cycles, req_ready, operator, imd_q[0], imd_q[1]);
            end
            step();
        end
        req_valid = 1'b0;
        consume();
    endtask

    task automatic test_back_to_back();
        bit ok;
        issue(MD_OP_MULL, 2'b00, 32'd7, 32'd2);
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'd14 || rsp_cycles !== 6'd3) begin bad++; $display("FAIL b2b_first got=%0d/%0d exp=14/3", rsp_data, rsp_cycles); end
        req_op = MD_OP_MULL; req_signed = 2'b00; req_a = 32'd5; req_b = 32'd1;
        req_valid = 1'b1; rsp_ready = 1'b1; #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
        step();
        req_valid = 1'b0; rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || mult_en !== 1'b1 || op_a !== 32'd5 || op_b !== 32'd1) begin bad++; $display("FAIL b2b_busy got=%b %b %h %h exp=0 1 5 1", rsp_valid, mult_en, op_a, op_b); end
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'd5 || rsp_cycles !== 6'd2) begin bad++; $display("FAIL b2b_second got=%0d/%0d exp=5/2", rsp_data, rsp_cycles); end
        consume();
    endtask

    task automatic test_reset_mid();
        bit ok;
        issue(MD_OP_DIV, 2'b00, 32'd1000, 32'd7);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || div_en !== 1'b0) begin bad++; $display("FAIL rstmid_state got=%b %b %b exp=1 0 0", req_ready, rsp_valid, div_en); end
        total++; if (imd_q[0] !== 34'h0 || imd_q[1] !== 34'h0 || rsp_cycles !== 6'd0) begin bad++; $display("FAIL rstmid_regs got=%h %h %0d exp=0 0 0", imd_q[0], imd_q[1], rsp_cycles); end
        repeat (40) step();
        total++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin bad++; $display("FAIL rstmid_norsp got=%b %h exp=0 0", rsp_valid, rsp_data); end
        issue(MD_OP_MULL, 2'b00, 32'd2, 32'd3);
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'd6 || rsp_cycles !== 6'd3) begin bad++; $display("FAIL rstmid_next got=%0d/%0d exp=6/3", rsp_data, rsp_cycles); end
        consume();
    endtask

    task automatic test_dit();
        bit ok;
        logic exp_dit;
`ifdef MULTDIV_DIT_EN
        exp_dit = 1'b1;
`else
        exp_dit = 1'b0;
`endif
        cfg_dit = 1'b1;
        issue(MD_OP_MULL, 2'b00, 32'd6, 32'd7);
        cfg_dit = 1'b0; #1;
        total++; if (dit_o !== exp_dit) begin bad++; $display("FAIL dit_out got=%b exp=%b", dit_o, exp_dit); end
        wait_rsp(ok);
        total++; if (!ok || rsp_data !== 32'd42) begin bad++; $display("FAIL dit_rsp got=%0d exp=42", rsp_data); end
        consume();
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = MD_OP_MULL; req_signed = 2'b00;
        req_a = '0; req_b = '0; rsp_ready = 1'b0; cfg_dit = 1'b0;
        alu_a = '0; alu_b = '0; stray_valid = 1'b0;
        test_reset();
        test_adder();
        test_mull();
        test_div_zero();
        test_div_signed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_dit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
